// File: rtl/branch_resolve_pkg.sv
// Shared types for the branch resolution slice: condition codes, FIFO entry
// layout, resolver states and the condition evaluator.
package branch_resolve_pkg;

    typedef logic [31:0] word32_t;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_cond_t;

    typedef struct packed {
        logic    pred;
        word32_t target;
        word32_t fallthru;
    } br_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EVAL    = 2'd1,
        RECOVER = 2'd2
    } br_state_t;

    // Unused encodings 010/011 resolve as not-taken.
    function automatic logic eval_cond(br_cond_t c, word32_t a, word32_t b);
        logic r;
        case (c)
            BR_BEQ:  r = (a == b);
            BR_BNE:  r = (a != b);
            BR_BLT:  r = ($signed(a) <  $signed(b));
            BR_BGE:  r = ($signed(a) >= $signed(b));
            BR_BLTU: r = (a <  b);
            BR_BGEU: r = (a >= b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Fetch-side and execute-side signals of the branch resolver, bundled so the
// bench (master) and resolver (slave) share one connection.
interface branch_resolve_if;
    import branch_resolve_pkg::*;

    logic     issuing_branch_i;
    logic     br_taken_i;
    word32_t  pc_target_i;
    word32_t  pc_fallthru_i;
    logic     fifo_full_o;
    logic     br_valid_i;
    logic     br_ready_o;
    br_cond_t br_cond_i;
    word32_t  rs1_val_i;
    word32_t  rs2_val_i;
    logic     cond_eval_o;
    logic     corr_pred_o;
    logic     flush_o;
    word32_t  redirect_pc_o;

    modport master (
        output issuing_branch_i, br_taken_i, pc_target_i, pc_fallthru_i,
        output br_valid_i, br_cond_i, rs1_val_i, rs2_val_i,
        input  fifo_full_o, br_ready_o, cond_eval_o, corr_pred_o,
        input  flush_o, redirect_pc_o
    );

    modport slave (
        input  issuing_branch_i, br_taken_i, pc_target_i, pc_fallthru_i,
        input  br_valid_i, br_cond_i, rs1_val_i, rs2_val_i,
        output fifo_full_o, br_ready_o, cond_eval_o, corr_pred_o,
        output flush_o, redirect_pc_o
    );
endinterface

// File: rtl/branch_fifo.sv
// In-order FIFO of outstanding predictions. Pointers carry a wrap bit so
// full and empty are distinguishable; clear wins over push and pop.
module branch_fifo
    import branch_resolve_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      reset_ni,
    input  logic      push_i,
    input  br_entry_t entry_i,
    input  logic      pop_i,
    input  logic      clear_i,
    output logic      full_o,
    output logic      empty_o,
    output br_entry_t head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    br_entry_t   mem_q [DEPTH];
    logic        wr_en, rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees the head slot, so a simultaneous push is allowed even when full.
    assign wr_en = push_i && (!full_o || pop_i) && !clear_i;
    assign rd_en = pop_i && !empty_o && !clear_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (rd_en) rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= entry_i;
    end

endmodule

// File: rtl/branch_resolve.sv
// Resolves queued branch predictions in program order, reports outcome to the
// predictor and raises a flush with the correct PC on a mispredict.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int RECOVER_CYCLES = 2
) (
    input logic             clk_i,
    input logic             reset_ni,
    branch_resolve_if.slave bus
);
    localparam int CW = $clog2(RECOVER_CYCLES + 1);

    br_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic      corr_q, corr_d;
    word32_t   redirect_q, redirect_d;

    br_entry_t push_entry, head;
    logic      full, empty, ready, accept, actual, flush;

    assign push_entry = '{pred: bus.br_taken_i, target: bus.pc_target_i,
                          fallthru: bus.pc_fallthru_i};

    branch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .push_i  (bus.issuing_branch_i),
        .entry_i (push_entry),
        .pop_i   (accept),
        .clear_i (flush),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    assign ready  = (state_q == IDLE) && !empty;
    assign accept = bus.br_valid_i && ready;
    assign actual = eval_cond(bus.br_cond_i, bus.rs1_val_i, bus.rs2_val_i);
    assign flush  = (state_q == EVAL) && !corr_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        corr_d     = corr_q;
        redirect_d = redirect_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EVAL;
                    corr_d  = (actual == head.pred);
                    // Only a mispredict moves the redirect PC; it otherwise holds.
                    if (actual != head.pred)
                        redirect_d = actual ? head.target : head.fallthru;
                end
            end
            EVAL: begin
                if (corr_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = RECOVER;
                    cnt_d   = CW'(RECOVER_CYCLES);
                end
            end
            RECOVER: begin
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            corr_q     <= 1'b0;
            redirect_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            corr_q     <= corr_d;
            redirect_q <= redirect_d;
        end
    end

    assign bus.fifo_full_o   = full;
    assign bus.br_ready_o    = ready;
    assign bus.cond_eval_o   = (state_q == EVAL);
    assign bus.corr_pred_o   = (state_q == EVAL) && corr_q;
    assign bus.flush_o       = flush;
    assign bus.redirect_pc_o = redirect_q;

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Back end of the branch prediction loop. Records every prediction fetch issues in an in-order FIFO.
- Evaluates each branch condition when the execute side delivers operands.
- Reports cond_eval_o/corr_pred_o to the predictor; the predictor updates its history on these.
- On a mispredict, raises a flush with the correct redirect PC and runs a short recovery sequence.

Parameters:
- DEPTH, 4, outstanding-branch FIFO entries (power of 2, >=2).
- RECOVER_CYCLES, 2, cycles br_ready_o stays low after a flush (>=1).

Ports:
- clk_i  in  1  system clock
- reset_ni  in  1  asynchronous active-low reset
- issuing_branch_i  in  1  fetch is writing a branch to the instr queue
- br_taken_i  in  1  prediction given to fetch for that branch
- pc_target_i  in  32  branch target PC (word32_t)
- pc_fallthru_i  in  32  branch PC + 4 (word32_t)
- fifo_full_o  out  1  no room for another branch; fetch must stall branch issue
- br_valid_i  in  1  execute presents the oldest branch's operands
- br_ready_o  out  1  block can accept operands
- br_cond_i  in  3  condition code (br_cond_t)
- rs1_val_i  in  32  operand 1
- rs2_val_i  in  32  operand 2
- cond_eval_o  out  1  one-cycle pulse: a branch resolved
- corr_pred_o  out  1  valid with cond_eval_o: prediction was correct
- flush_o  out  1  one-cycle pulse: mispredict, squash younger work
- redirect_pc_o  out  32  correct next PC; valid with flush_o

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty, pointers 0, state IDLE, recovery counter 0.
  - All outputs 0, except br_ready_o, which is 0 because the FIFO is empty.
- FIFO:
  - Entry = {pred, target, fallthru}.
  - Pointers carry an extra wrap bit. Full = indices equal and wrap bits differ. Empty = pointers equal.
  - Push when issuing_branch_i && !fifo_full_o.
  - A push while full is dropped; fetch guarantees this never happens.
  - Pointers wrap modulo DEPTH.
  - A push and a pop in the same cycle are both legal when the FIFO is full.
- Accept:
  - br_ready_o = (state==IDLE) && !empty.
  - A transfer is br_valid_i && br_ready_o. Branches resolve strictly in program order.
- Evaluation is combinational on accept, with the result registered. Conditions:
  - BEQ 000: rs1 == rs2
  - BNE 001: rs1 != rs2
  - BLT 100: signed rs1 < rs2
  - BGE 101: signed rs1 >= rs2
  - BLTU 110: unsigned rs1 < rs2
  - BGEU 111: unsigned rs1 >= rs2
  - 010 and 011 evaluate as not-taken.
- Latency 1: the cycle after accept:
  - cond_eval_o=1.
  - corr_pred_o = (actual == head.pred).
  - The head entry is popped at the accept edge.
- Mispredict (same cycle as cond_eval_o):
  - flush_o=1.
  - redirect_pc_o = actual ? target : fallthru.
  - The FIFO is cleared at that same edge: all younger entries are wrong-path.
  - A push coinciding with the flush cycle is discarded.
  - State goes to RECOVER.
- redirect_pc_o holds its last value when flush_o=0.
- State machine:
  - IDLE -> EVAL on accept.
  - EVAL -> IDLE if correct.
  - EVAL -> RECOVER if mispredict; counter loads RECOVER_CYCLES.
  - RECOVER: br_ready_o=0, pushes accepted, counter decrements; exit to IDLE when it reaches 1.
  - EVAL: br_ready_o=0, so at most one branch is in flight. Throughput is one branch per 2 cycles.
- Reset mid-operation: everything returns to reset values immediately. No cond_eval_o or flush_o pulse is emitted for the in-flight branch.
- br_valid_i while the FIFO is empty is a protocol error and is ignored (ready stays low).

Decomposition:
- Shared data_types package:
  - br_cond_t enum (BR_BEQ … BR_BGEU).
  - br_entry_t struct {pred, target, fallthru}, using word32_t.
  - br_state_t enum {IDLE, EVAL, RECOVER}.
- Sub-module branch_fifo (parameterised DEPTH):
  - Holds br_entry_t.
  - Provides push/pop/clear, full/empty and head outputs.
- Condition compare and FSM live in branch_resolve.

Test Plan:
- Reset, push {pred=1, target=0x100, fallthru=0x44}, operands BEQ 5,5 -> next cycle cond_eval_o=1, corr_pred_o=1, flush_o=0; FIFO empty.
- Push {pred=0, 0x200, 0x80}, BLT rs1=0xFFFFFFFF rs2=1 -> taken: corr_pred_o=0, flush_o=1, redirect_pc_o=0x200; br_ready_o low 2 cycles.
- Same BLTU 0xFFFFFFFF,1 with pred=1 -> not taken: flush_o=1, redirect_pc_o=fallthru.
- Push 4 branches (DEPTH=4) -> fifo_full_o=1; a 5th push is ignored. One resolve -> fifo_full_o=0; a push+pop in the same cycle keeps the count at 3→3.
- Three entries queued, first mispredicts -> FIFO cleared; a push in the flush cycle is discarded; a push during RECOVER is kept and resolves afterwards.
- reset_ni asserted in the EVAL cycle, asynchronously -> outputs 0 immediately, no cond_eval_o pulse, FIFO empty after release.
